// File: rtl/img_bin_deci.sv
// img_bin_deci -- 2x2 binning / decimation of a packed pixel stream.
//
// Even image rows are parked in a one-line buffer. Each odd-row beat is paired
// with the buffered beat above it. Every 2x2 block of pixels is reduced to one
// output pixel by averaging, by a saturated sum, or by subsampling, so each
// odd-row input beat yields one output beat half as wide. Pipeline is three
// registers deep: input register, pair sums, final op/pack.
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   din           PIX_PER_BEAT packed pixels, pixel i at [i*PIX_W +: PIX_W]
//   din_valid     din qualifier (no backpressure)
//   frame_start   one-cycle pulse marking a new frame; latches mode
//   mode          00 average, 01 saturated sum, 10 subsample, 11 = 00
//   dout          PIX_PER_BEAT/2 packed output pixels, zero when not valid
//   dout_valid    dout qualifier
//   dout_row_last marks the last dout beat of each output row
//   frame_done    one-cycle pulse the cycle after the last dout beat of a frame
//   frame_err     one-cycle pulse on a framing violation
module img_bin_deci #(
  parameter int IMG_WIDTH    = 2048,
  parameter int IMG_HEIGHT   = 2048,
  parameter int PIX_PER_BEAT = 8,
  parameter int PIX_W        = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [PIX_PER_BEAT*PIX_W-1:0]       din,
  input  logic                                din_valid,
  input  logic                                frame_start,
  input  logic [1:0]                          mode,
  output logic [PIX_PER_BEAT/2*PIX_W-1:0]     dout,
  output logic                                dout_valid,
  output logic                                dout_row_last,
  output logic                                frame_done,
  output logic                                frame_err
);

  localparam int LINE_BEATS = IMG_WIDTH / PIX_PER_BEAT;
  localparam int HALF       = PIX_PER_BEAT / 2;
  localparam int BW         = PIX_PER_BEAT * PIX_W;
  localparam int OW         = HALF * PIX_W;
  localparam int SW         = PIX_W + 2;
  localparam int CW         = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int RW         = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0]    COL_LAST = CW'(LINE_BEATS - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [PIX_W-1:0] PIX_MAX  = {PIX_W{1'b1}};

  localparam logic [1:0] MODE_AVG = 2'b00;
  localparam logic [1:0] MODE_SAT = 2'b01;
  localparam logic [1:0] MODE_SUB = 2'b10;

  // Sum of a 2x2 block, widened so four full-scale pixels cannot overflow.
  function automatic logic [SW-1:0] quad_sum(input logic [PIX_W-1:0] a,
                                             input logic [PIX_W-1:0] b,
                                             input logic [PIX_W-1:0] c,
                                             input logic [PIX_W-1:0] d);
    return SW'(a) + SW'(b) + SW'(c) + SW'(d);
  endfunction

  // Mode 11 is an alias of the average mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_AVG : m;
  endfunction

  // Frame position and state
  logic [CW-1:0] col_cnt_r;
  logic [RW-1:0] row_cnt_r;
  logic          frame_over_r;   // full frame received, waiting for frame_start
  logic [1:0]    mode_r;

  // Position of the beat in this cycle, as seen after any frame_start
  logic [CW-1:0] cur_col_s;
  logic [RW-1:0] cur_row_s;
  logic          cur_over_s;
  logic [1:0]    cur_mode_s;
  logic          accept_s;
  logic          drop_s;
  logic          err_s;
  logic          col_last_s;
  logic          row_last_s;
  logic [BW-1:0] top_s;

  logic [BW-1:0] line_buf [LINE_BEATS];

  // Stage 1: input register
  logic          s1_valid_r;
  logic [BW-1:0] s1_top_r;
  logic [BW-1:0] s1_bot_r;
  logic          s1_col_last_r;
  logic          s1_frame_last_r;
  logic [1:0]    s1_mode_r;

  // Stage 2: pair sums
  logic [HALF*SW-1:0] sum_s;
  logic [OW-1:0]      sub_s;
  logic               s2_valid_r;
  logic [HALF*SW-1:0] s2_sum_r;
  logic [OW-1:0]      s2_sub_r;
  logic               s2_col_last_r;
  logic               s2_frame_last_r;
  logic [1:0]         s2_mode_r;

  // Stage 3: final op
  logic [OW-1:0] res_s;
  logic [SW-1:0] sum_k_s;
  logic          out_frame_last_r;

  // Resolve the effective position: a frame_start in the same cycle as a beat makes that beat col 0, row 0.
  always_comb begin
    cur_col_s  = col_cnt_r;
    cur_row_s  = row_cnt_r;
    cur_over_s = frame_over_r;
    cur_mode_s = mode_r;
    if (frame_start) begin
      cur_col_s  = '0;
      cur_row_s  = '0;
      cur_over_s = 1'b0;
      cur_mode_s = norm_mode(mode);
    end else begin
      cur_col_s  = col_cnt_r;
      cur_row_s  = row_cnt_r;
      cur_over_s = frame_over_r;
      cur_mode_s = mode_r;
    end
    accept_s   = din_valid & ~cur_over_s;
    drop_s     = din_valid & cur_over_s;
    col_last_s = (cur_col_s == COL_LAST);
    row_last_s = (cur_row_s == ROW_LAST);
    top_s      = line_buf[cur_col_s];
    // Restarting a partially received frame, or a beat past the frame end, is a violation.
    err_s      = (frame_start & ((col_cnt_r != '0) | (row_cnt_r != '0))) | drop_s;
  end

  // Column/row counters, end-of-frame flag and latched mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_r    <= '0;
      row_cnt_r    <= '0;
      frame_over_r <= 1'b0;
      mode_r       <= MODE_AVG;
    end else begin
      mode_r <= cur_mode_s;
      if (accept_s) begin
        if (col_last_s) begin
          col_cnt_r <= '0;
          if (row_last_s) begin
            row_cnt_r    <= '0;
            frame_over_r <= 1'b1;
          end else begin
            row_cnt_r    <= cur_row_s + RW'(1);
            frame_over_r <= 1'b0;
          end
        end else begin
          col_cnt_r    <= cur_col_s + CW'(1);
          row_cnt_r    <= cur_row_s;
          frame_over_r <= cur_over_s;
        end
      end else begin
        col_cnt_r    <= cur_col_s;
        row_cnt_r    <= cur_row_s;
        frame_over_r <= cur_over_s;
      end
    end
  end

  // Line buffer: even rows are written and never cleared; odd rows only read.
  always_ff @(posedge clk) begin
    if (accept_s && !cur_row_s[0]) begin
      line_buf[cur_col_s] <= din;
    end
  end

  // Stage 1: capture top (buffered) and bottom (live) beats for odd rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r      <= 1'b0;
      s1_top_r        <= '0;
      s1_bot_r        <= '0;
      s1_col_last_r   <= 1'b0;
      s1_frame_last_r <= 1'b0;
      s1_mode_r       <= MODE_AVG;
    end else begin
      s1_valid_r      <= accept_s & cur_row_s[0];
      s1_top_r        <= top_s;
      s1_bot_r        <= din;
      s1_col_last_r   <= col_last_s;
      s1_frame_last_r <= col_last_s & row_last_s;
      s1_mode_r       <= cur_mode_s;
    end
  end

  // 2x2 block sums and the top-left pixel used by subsampling.
  always_comb begin
    sum_s = '0;
    sub_s = '0;
    for (int k = 0; k < HALF; k++) begin
      sum_s[k*SW +: SW] = quad_sum(s1_top_r[(2*k)*PIX_W +: PIX_W],
                                   s1_top_r[(2*k+1)*PIX_W +: PIX_W],
                                   s1_bot_r[(2*k)*PIX_W +: PIX_W],
                                   s1_bot_r[(2*k+1)*PIX_W +: PIX_W]);
      sub_s[k*PIX_W +: PIX_W] = s1_top_r[(2*k)*PIX_W +: PIX_W];
    end
  end

  // Stage 2: register the sums; the beat's own mode travels with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r      <= 1'b0;
      s2_sum_r        <= '0;
      s2_sub_r        <= '0;
      s2_col_last_r   <= 1'b0;
      s2_frame_last_r <= 1'b0;
      s2_mode_r       <= MODE_AVG;
    end else begin
      s2_valid_r      <= s1_valid_r;
      s2_sum_r        <= sum_s;
      s2_sub_r        <= sub_s;
      s2_col_last_r   <= s1_col_last_r;
      s2_frame_last_r <= s1_frame_last_r;
      s2_mode_r       <= s1_mode_r;
    end
  end

  // Final per-pixel operation selected by mode.
  always_comb begin
    res_s   = '0;
    sum_k_s = '0;
    for (int k = 0; k < HALF; k++) begin
      sum_k_s = s2_sum_r[k*SW +: SW];
      case (s2_mode_r)
        MODE_AVG: res_s[k*PIX_W +: PIX_W] = sum_k_s[SW-1:2];
        MODE_SAT: begin
          if (sum_k_s > {2'b00, PIX_MAX}) begin
            res_s[k*PIX_W +: PIX_W] = PIX_MAX;
          end else begin
            res_s[k*PIX_W +: PIX_W] = sum_k_s[PIX_W-1:0];
          end
        end
        MODE_SUB: res_s[k*PIX_W +: PIX_W] = s2_sub_r[k*PIX_W +: PIX_W];
        default:  res_s[k*PIX_W +: PIX_W] = sum_k_s[SW-1:2];
      endcase
    end
  end

  // Stage 3: registered outputs; dout is forced to zero between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout             <= '0;
      dout_valid       <= 1'b0;
      dout_row_last    <= 1'b0;
      out_frame_last_r <= 1'b0;
      frame_done       <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      dout             <= s2_valid_r ? res_s : '0;
      dout_valid       <= s2_valid_r;
      dout_row_last    <= s2_valid_r & s2_col_last_r;
      out_frame_last_r <= s2_valid_r & s2_frame_last_r;
      frame_done       <= dout_valid & out_frame_last_r;
      frame_err        <= err_s;
    end
  end

endmodule

// File: tb/tb_img_bin_deci.sv
module tb_img_bin_deci;

  localparam int W   = 16;
  localparam int H   = 4;
  localparam int PPB = 8;
  localparam int PW  = 8;
  localparam int LB  = W / PPB;
  localparam int BW  = PPB * PW;
  localparam int OW  = PPB / 2 * PW;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_row_last;
  logic          frame_done;
  logic          frame_err;

  img_bin_deci #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_PER_BEAT(PPB), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .mode(mode), .dout(dout), .dout_valid(dout_valid),
    .dout_row_last(dout_row_last), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] data;
    bit            row_last;
    int            at;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_err[MAXC];
  bit   exp_done[MAXC];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state: beat index within the frame, image row above.
  int   m_idx = 0;
  bit   m_over = 1'b0;
  int   m_mode = 0;
  int   top_pix[W];
  bit   gap_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mark(ref bit arr[MAXC], input int c);
    if (c < MAXC) arr[c] = 1'b1;
  endtask

  // Behavioural model: whole-image pixel arithmetic on integers.
  task automatic model(input bit v, input bit fs, input logic [BW-1:0] d,
                       input logic [1:0] md, input int c);
    bit err = 1'b0;
    int row, col, s, a, r;
    int p[PPB];
    logic [OW-1:0] o;
    if (fs) begin
      if (m_idx != 0) err = 1'b1;
      m_idx  = 0;
      m_over = 1'b0;
      m_mode = (md == 2'b11) ? 0 : int'(md);
    end
    if (v) begin
      if (m_over) begin
        err = 1'b1;
      end else begin
        row = m_idx / LB;
        col = m_idx % LB;
        for (int i = 0; i < PPB; i++) p[i] = int'(d[i*PW +: PW]);
        if (row % 2 == 0) begin
          for (int i = 0; i < PPB; i++) top_pix[col*PPB + i] = p[i];
        end else begin
          o = '0;
          for (int k = 0; k < PPB/2; k++) begin
            a = top_pix[col*PPB + 2*k];
            s = a + top_pix[col*PPB + 2*k + 1] + p[2*k] + p[2*k+1];
            case (m_mode)
              1:       r = (s > 255) ? 255 : s;
              2:       r = a;
              default: r = s / 4;
            endcase
            o[k*PW +: PW] = r[7:0];
          end
          exp_q.push_back('{o, (col == LB-1), c + 3});
          if (row == H-1 && col == LB-1) mark(exp_done, c + 4);
        end
        if (m_idx == LB*H - 1) begin
          m_idx  = 0;
          m_over = 1'b1;
        end else begin
          m_idx++;
        end
      end
    end
    if (err) mark(exp_err, c + 1);
  endtask

  task automatic drive(input bit v, input bit fs, input logic [BW-1:0] d, input logic [1:0] md);
    @(posedge clk);
    #1;
    din_valid   = v;
    frame_start = fs;
    din         = d;
    mode        = md;
    model(v, fs, d, md, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, {$urandom, $urandom}, 2'($urandom));
  endtask

  task automatic beat(input logic [BW-1:0] d, input bit fs, input logic [1:0] md);
    if (gap_en) idle($urandom_range(0, 2));
    drive(1'b1, fs, d, fs ? md : 2'($urandom));
  endtask

  function automatic logic [BW-1:0] fill(input logic [7:0] v);
    return {PPB{v}};
  endfunction

  function automatic logic [BW-1:0] ramp(input int base);
    logic [BW-1:0] d;
    for (int i = 0; i < PPB; i++) d[i*PW +: PW] = 8'(base + i);
    return d;
  endfunction

  task automatic rand_beats(input int n);
    for (int i = 0; i < n; i++) beat({$urandom, $urandom}, 1'b0, 2'b00);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_dout_valid", 64'(dout_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("dout", 64'(dout), 64'(e.data));
        chk("dout_row_last", 64'(dout_row_last), 64'(e.row_last));
        chk("latency_cycle", 64'(cyc), 64'(e.at));
      end
    end else begin
      chk("dout_idle_zero", 64'(dout), 64'd0);
      chk("row_last_idle", 64'(dout_row_last), 64'd0);
      if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_dout", 64'(dout_valid), 64'd1);
      end
    end
    if (cyc < MAXC) begin
      chk("frame_err", 64'(frame_err), 64'(exp_err[cyc]));
      chk("frame_done", 64'(frame_done), 64'(exp_done[cyc]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_dout_valid", 64'(dout_valid), 64'd0);
    chk("reset_frame_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Mode 00: 10s over 13s -> 11
    beat(fill(8'd10), 1'b1, 2'b00);
    beat(fill(8'd10), 1'b0, 2'b00);
    beat(fill(8'd13), 1'b0, 2'b00);
    beat(fill(8'd13), 1'b0, 2'b00);
    rand_beats(4);
    idle(6);

    // Mode 01: all 200 -> 255, frame_done after the 4th beat
    beat(fill(8'd200), 1'b1, 2'b01);
    for (int i = 0; i < 7; i++) beat(fill(8'd200), 1'b0, 2'b00);
    idle(6);

    // Mode 10: ramp over 99 -> even indices
    beat(ramp(0), 1'b1, 2'b10);
    beat(ramp(8), 1'b0, 2'b00);
    beat(fill(8'd99), 1'b0, 2'b00);
    beat(fill(8'd99), 1'b0, 2'b00);
    rand_beats(4);
    idle(6);

    // Mode 11 behaves as 00, with full-scale pixels
    beat(fill(8'd255), 1'b1, 2'b11);
    rand_beats(7);
    idle(3);

    // Framing: restart after 3 beats, then a 9th beat after a full frame
    beat({$urandom, $urandom}, 1'b1, 2'b00);
    rand_beats(2);
    beat({$urandom, $urandom}, 1'b1, 2'b01);
    rand_beats(7);
    beat({$urandom, $urandom}, 1'b0, 2'b00);
    idle(2);
    beat({$urandom, $urandom}, 1'b0, 2'b00);
    idle(6);

    // Random frames with random gaps and modes
    gap_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      beat({$urandom, $urandom}, 1'b1, 2'($urandom));
      rand_beats(7);
    end
    idle(6);
    gap_en = 1'b0;

    // Reset in the middle of row 1 with a beat in flight
    beat(fill(8'd40), 1'b1, 2'b01);
    beat(fill(8'd40), 1'b0, 2'b00);
    beat(fill(8'd50), 1'b0, 2'b00);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_dout", 64'(dout), 64'd0);
    chk("midreset_dout_valid", 64'(dout_valid), 64'd0);
    chk("midreset_row_last", 64'(dout_row_last), 64'd0);
    chk("midreset_frame_done", 64'(frame_done), 64'd0);
    chk("midreset_frame_err", 64'(frame_err), 64'd0);
    exp_q.delete();
    for (int c = cyc; c < MAXC; c++) begin
      exp_err[c]  = 1'b0;
      exp_done[c] = 1'b0;
    end
    m_idx  = 0;
    m_over = 1'b0;
    m_mode = 0;
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    // After reset: frame in progress at row 0 with average mode, no frame_start
    beat(fill(8'd20), 1'b0, 2'b00);
    beat(fill(8'd20), 1'b0, 2'b00);
    beat(fill(8'd24), 1'b0, 2'b00);
    beat(fill(8'd24), 1'b0, 2'b00);
    rand_beats(4);
    idle(10);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/img_bin_deci.md
IMG_BIN_DECI -- requirements
Module: img_bin_deci

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 2048, pixels per image row.
REQ-002 SHALL have parameter IMG_HEIGHT, default 2048, rows per frame.
REQ-003 SHALL have parameter PIX_PER_BEAT, default 8, pixels per input beat.
REQ-004 SHALL have parameter PIX_W, default 8, bits per pixel.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port din, input, PIX_PER_BEAT*PIX_W, packed pixels; pixel i at bits [i*PIX_W +: PIX_W], i=0 leftmost.
REQ-009 SHALL have port din_valid, input, 1, din qualifier; there is no backpressure.
REQ-010 SHALL have port frame_start, input, 1, single-cycle pulse marking the start of a frame.
REQ-011 SHALL have port mode, input, 2, decimation mode.
REQ-012 SHALL have port dout, output, PIX_PER_BEAT/2*PIX_W, packed decimated pixels in the same ordering as din.
REQ-013 SHALL have port dout_valid, output, 1, dout qualifier.
REQ-014 SHALL have port dout_row_last, output, 1, asserted with the last dout beat of each output row.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse in the cycle after the last dout beat of a frame.
REQ-016 SHALL have port frame_err, output, 1, one-cycle pulse on a framing violation.

Function
REQ-017 SHALL require IMG_WIDTH divisible by PIX_PER_BEAT, PIX_PER_BEAT even, and IMG_HEIGHT even; LINE_BEATS = IMG_WIDTH/PIX_PER_BEAT.
REQ-018 SHALL count accepted beats with col_cnt (0..LINE_BEATS-1, wraps to 0 and increments row_cnt) and row_cnt (0..IMG_HEIGHT-1).
REQ-019 SHALL write even-row beats into an internal LINE_BEATS x PIX_PER_BEAT*PIX_W line buffer at address col_cnt, with no output.
REQ-020 SHALL, for each odd-row beat, read line buffer[col_cnt] as the top row and din as the bottom row, and produce exactly one dout beat.
REQ-021 SHALL form output pixel k from the 2x2 block of top/bottom pixels 2k and 2k+1; sums are PIX_W+2 bits wide, with no intermediate overflow.
REQ-022 SHALL support mode 00, average = sum>>2 (truncating).
REQ-023 SHALL support mode 01, saturated sum = min(sum, 2^PIX_W-1).
REQ-024 SHALL support mode 10, subsample = top-row pixel 2k.
REQ-025 SHALL treat mode 11 as 00.
REQ-026 SHALL latch mode only on frame_start; mode is constant for the whole frame.
REQ-027 SHALL have a fixed latency of 3: an odd-row beat accepted at cycle N produces dout_valid at N+3; stages are input register, pair sums, final op/pack.
REQ-028 SHALL drive dout to 0 when dout_valid is low.
REQ-029 SHALL sustain full throughput: din_valid high on every cycle gives one dout per odd-row beat, with no bubbles.
REQ-030 SHALL honour gaps: din_valid low freezes the counters and inserts no output.
REQ-031 SHALL assert dout_row_last when the contributing beat had col_cnt = LINE_BEATS-1.
REQ-032 SHALL pulse frame_done one cycle after the dout_row_last of row_cnt = IMG_HEIGHT-1.
REQ-033 SHALL, on frame_start, clear col_cnt and row_cnt and latch mode.
REQ-034 SHALL treat frame_start and din_valid in the same cycle as that beat being col 0, row 0 of the new frame.
REQ-035 SHALL, on frame_start while col_cnt != 0 or row_cnt != 0, pulse frame_err and abandon the partial frame; dout beats already in the pipeline still emerge.
REQ-036 SHALL, on beats after the final beat of a frame and before the next frame_start, drop them, produce no output, and pulse frame_err once per dropped beat.
REQ-037 SHALL not clear the line buffer contents on frame_start or reset; correctness relies on even rows always being written before they are read.

Reset
REQ-038 SHALL, on rst_n low, asynchronously force dout=0, dout_valid=0, dout_row_last=0, frame_done=0, frame_err=0, col_cnt=0, row_cnt=0, latched mode=00, and all pipeline valids=0.
REQ-039 SHALL, after release, behave as if frame_start had been seen with mode 00.
REQ-040 SHALL treat reset mid-frame as discarding all in-flight beats; no dout_valid may follow until new odd-row beats arrive.

Verification (IMG_WIDTH=16, IMG_HEIGHT=4, PIX_PER_BEAT=8, PIX_W=8)
REQ-041 SHALL verify mode 00: row0 all 10, row1 all 13 -> 2 dout beats, each pixel 11 (46>>2), dout_row_last on the 2nd, at cycle +3.
REQ-042 SHALL verify mode 01: all pixels 200 over 4 rows -> 4 dout beats, each pixel 255; frame_done pulse 1 cycle after the 4th beat.
REQ-043 SHALL verify mode 10: row0 pixels = index 0..15, row1 = 99 -> dout beats {0,2,4,6} and {8,10,12,14}.
REQ-044 SHALL verify framing: frame_start after 3 beats -> frame_err pulse, new frame starts at col 0; a 9th beat after a full frame -> dropped, frame_err pulse, no dout.
REQ-045 SHALL verify gaps/reset: random din_valid gaps give results identical to gapless input; rst_n low mid-row1 -> all outputs 0 immediately, no stale dout afterwards.
